// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: DLX decode operand formation, load-use hazard detection and ID/EX register
module id_ex_hazard_stage #(
    parameter int SIZE     = 32,
    parameter int CTRL_W   = 16,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [0:31]       instr,
    input  logic [0:SIZE-1]   nextPC_in,
    input  logic [0:SIZE-1]   busA_in,
    input  logic [0:SIZE-1]   busB_in,
    input  logic [0:CTRL_W-1] ctrl_in,
    input  logic              rtype,
    input  logic              pc_to_reg,
    input  logic              ext_op,
    input  logic              lhi_op,
    input  logic              jump,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [0:SIZE-1]   nextPC_out,
    output logic [0:SIZE-1]   busA_out,
    output logic [0:SIZE-1]   busB_out,
    output logic [0:SIZE-1]   store_out,
    output logic [0:SIZE-1]   imm26_out,
    output logic [0:CTRL_W-1] ctrl_out,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_write,
    output logic [0:REG_AW-1] destReg
);
    logic [0:REG_AW-1] rs1, rs2, rd, dest;
    logic [0:SIZE-1]   imm_z, imm_s, imm26, op_a, op_b;
    logic              use_rs1, use_rs2, haz, ld, unused_opcode;

    assign unused_opcode = ^instr[0:5];
    assign rs1   = instr[11-REG_AW:10];
    assign rs2   = instr[16-REG_AW:15];
    assign rd    = instr[21-REG_AW:20];
    assign imm_z = {{(SIZE-16){1'b0}}, instr[16:31]};
    assign imm_s = {{(SIZE-16){instr[16]}}, instr[16:31]};
    assign imm26 = {{(SIZE-26){instr[6]}}, instr[6:31]};
    // LHI feeds the shifter: immediate on A, constant shift of 16 on B
    assign op_a  = lhi_op ? imm_z : busA_in;
    assign op_b  = lhi_op ? SIZE'(16) : rtype ? busB_in : ext_op ? imm_s : imm_z;
    assign dest  = pc_to_reg ? REG_AW'(LINK_REG) : rtype ? rd : rs2;

    assign use_rs1  = !lhi_op && !(jump && !rtype);
    assign use_rs2  = rtype || mem_write;
    assign haz      = if_valid && ex_valid && ex_mem_to_reg && destReg != '0 &&
                      ((use_rs1 && rs1 == destReg) || (use_rs2 && rs2 == destReg));
    assign stall_if = haz || ex_stall;
    // flush and hazard both resolve to a zeroed bubble; ex_stall alone holds
    assign ld       = if_valid && !flush && !haz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            nextPC_out    <= '0;
            busA_out      <= '0;
            busB_out      <= '0;
            store_out     <= '0;
            imm26_out     <= '0;
            ctrl_out      <= '0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            destReg       <= '0;
        end else if (flush || !ex_stall) begin
            ex_valid      <= ld;
            nextPC_out    <= ld ? nextPC_in : '0;
            busA_out      <= ld ? op_a : '0;
            busB_out      <= ld ? op_b : '0;
            store_out     <= ld ? busB_in : '0;
            imm26_out     <= ld ? imm26 : '0;
            ctrl_out      <= ld ? ctrl_in : '0;
            ex_mem_to_reg <= ld && mem_to_reg;
            ex_reg_write  <= ld && reg_write;
            ex_mem_write  <= ld && mem_write;
            destReg       <= ld ? dest : '0;
        end
    end
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: directed checks of operand formation, load-use bubbles, flush and hold
module tb_id_ex_hazard_stage;
    logic        clk = 0, reset = 1, if_valid = 0;
    logic [0:31] instr = 0, nextPC_in = 0, busA_in = 0, busB_in = 0;
    logic [0:15] ctrl_in = 0;
    logic        rtype = 0, pc_to_reg = 0, ext_op = 0, lhi_op = 0, jump = 0;
    logic        mem_write = 0, mem_to_reg = 0, reg_write = 0, flush = 0, ex_stall = 0;
    logic        stall_if, ex_valid, ex_mem_to_reg, ex_reg_write, ex_mem_write;
    logic [0:31] nextPC_out, busA_out, busB_out, store_out, imm26_out;
    logic [0:15] ctrl_out;
    logic [0:4]  destReg;
    int checks = 0, failures = 0;

    localparam logic [7:0] F_LW = 8'h23, F_ADD = 8'h81, F_ADDI = 8'h21, F_LHI = 8'h11, F_JAL = 8'h49, F_SW = 8'h24;

    id_ex_hazard_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .instr(instr), .nextPC_in(nextPC_in),
        .busA_in(busA_in), .busB_in(busB_in), .ctrl_in(ctrl_in), .rtype(rtype), .pc_to_reg(pc_to_reg),
        .ext_op(ext_op), .lhi_op(lhi_op), .jump(jump), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .flush(flush), .ex_stall(ex_stall), .stall_if(stall_if), .ex_valid(ex_valid),
        .nextPC_out(nextPC_out), .busA_out(busA_out), .busB_out(busB_out), .store_out(store_out),
        .imm26_out(imm26_out), .ctrl_out(ctrl_out), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .destReg(destReg)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [0:31] i, input logic [7:0] f, input logic [0:31] a, input logic [0:31] b);
        @(negedge clk);
        instr = i;
        {rtype, pc_to_reg, ext_op, lhi_op, jump, mem_write, mem_to_reg, reg_write} = f;
        busA_in = a;
        busB_in = b;
        if_valid = 1;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive({6'h08, 5'd1, 5'd3, 16'hFFFF}, F_ADDI, 32'h10, 32'h55);
        tick;
        @(negedge clk);
        reset = 1;
        #1;
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
        checks++; if (busB_out !== 32'h0) begin failures++; $display("FAIL reset_busB got=%0h exp=0", busB_out); end
        checks++; if (destReg !== 5'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", destReg); end
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_if); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_addi;
        ctrl_in = 16'hA5C3;
        drive({6'h08, 5'd1, 5'd3, 16'hFFFF}, F_ADDI, 32'h10, 32'h55);
        tick;
        checks++; if (busB_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_busB got=%0h exp=ffffffff", busB_out); end
        checks++; if (busA_out !== 32'h10) begin failures++; $display("FAIL addi_busA got=%0h exp=10", busA_out); end
        checks++; if (destReg !== 5'd3) begin failures++; $display("FAIL addi_dest got=%0d exp=3", destReg); end
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", ex_valid); end
        checks++; if (store_out !== 32'h55) begin failures++; $display("FAIL addi_store got=%0h exp=55", store_out); end
        checks++; if (imm26_out !== 32'h0023FFFF) begin failures++; $display("FAIL addi_imm26 got=%0h exp=23ffff", imm26_out); end
        checks++; if (ctrl_out !== 16'hA5C3) begin failures++; $display("FAIL addi_ctrl got=%0h exp=a5c3", ctrl_out); end
        checks++; if ({ex_mem_to_reg, ex_reg_write, ex_mem_write} !== 3'b010) begin failures++; $display("FAIL addi_flags got=%0b exp=010", {ex_mem_to_reg, ex_reg_write, ex_mem_write}); end
    endtask

    task automatic test_load_use;
        drive({6'h23, 5'd2, 5'd5, 16'h0000}, F_LW, 32'h100, 32'h0);
        tick;
        checks++; if (ex_mem_to_reg !== 1'b1 || destReg !== 5'd5) begin failures++; $display("FAIL lw_load got=%0h/%0d exp=1/5", ex_mem_to_reg, destReg); end
        drive({6'h00, 5'd5, 5'd7, 5'd6, 11'h020}, F_ADD, 32'h77, 32'h88);
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0h exp=1", stall_if); end
        tick;
        checks++; if (ex_valid !== 1'b0 || destReg !== 5'd0) begin failures++; $display("FAIL lu_bubble got=%0h/%0d exp=0/0", ex_valid, destReg); end
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL lu_release got=%0h exp=0", stall_if); end
        tick;
        checks++; if (ex_valid !== 1'b1 || destReg !== 5'd6) begin failures++; $display("FAIL lu_add got=%0h/%0d exp=1/6", ex_valid, destReg); end
        checks++; if (busA_out !== 32'h77 || busB_out !== 32'h88) begin failures++; $display("FAIL lu_ops got=%0h/%0h exp=77/88", busA_out, busB_out); end
    endtask

    task automatic test_no_hazard;
        drive({6'h23, 5'd2, 5'd0, 16'h0000}, F_LW, 32'h0, 32'h0);
        tick;
        drive({6'h00, 5'd0, 5'd7, 5'd6, 11'h020}, F_ADD, 32'h1, 32'h2);
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0h exp=0", stall_if); end
        tick;
        checks++; if (ex_valid !== 1'b1 || destReg !== 5'd6) begin failures++; $display("FAIL r0_add got=%0h/%0d exp=1/6", ex_valid, destReg); end
        drive({6'h23, 5'd2, 5'd5, 16'h0000}, F_LW, 32'h0, 32'h0);
        tick;
        drive({6'h0F, 5'd5, 5'd5, 16'h1234}, F_LHI, 32'hDEAD, 32'hBEEF);
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL lhi_stall got=%0h exp=0", stall_if); end
        tick;
        checks++; if (busA_out !== 32'h00001234) begin failures++; $display("FAIL lhi_busA got=%0h exp=1234", busA_out); end
        checks++; if (busB_out !== 32'd16) begin failures++; $display("FAIL lhi_busB got=%0h exp=10", busB_out); end
        checks++; if (ex_valid !== 1'b1 || destReg !== 5'd5) begin failures++; $display("FAIL lhi_dest got=%0h/%0d exp=1/5", ex_valid, destReg); end
    endtask

    task automatic test_jal;
        nextPC_in = 32'h104;
        drive({6'h03, 26'h3FFFFF0}, F_JAL, 32'h0, 32'h0);
        tick;
        checks++; if (destReg !== 5'd31) begin failures++; $display("FAIL jal_dest got=%0d exp=31", destReg); end
        checks++; if (nextPC_out !== 32'h104) begin failures++; $display("FAIL jal_pc got=%0h exp=104", nextPC_out); end
        checks++; if (imm26_out !== 32'hFFFFFFF0) begin failures++; $display("FAIL jal_imm26 got=%0h exp=fffffff0", imm26_out); end
    endtask

    task automatic test_stall_flush;
        drive({6'h08, 5'd1, 5'd3, 16'hFFFF}, F_ADDI, 32'h10, 32'h55);
        tick;
        drive({6'h00, 5'd1, 5'd2, 5'd9, 11'h020}, F_ADD, 32'h1, 32'h2);
        ex_stall = 1;
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL hold_stall got=%0h exp=1", stall_if); end
        tick;
        checks++; if (ex_valid !== 1'b1 || destReg !== 5'd3 || busB_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL hold_regs got=%0h/%0d/%0h exp=1/3/ffffffff", ex_valid, destReg, busB_out); end
        @(negedge clk);
        flush = 1;
        tick;
        checks++; if (ex_valid !== 1'b0 || destReg !== 5'd0 || busB_out !== 32'h0 || ctrl_out !== 16'h0) begin failures++; $display("FAIL flush_bubble got=%0h/%0d/%0h/%0h exp=0/0/0/0", ex_valid, destReg, busB_out, ctrl_out); end
        @(negedge clk);
        flush = 0;
        tick;
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin failures++; $display("FAIL flush_stays got=%0h/%0h exp=0/0", ex_valid, ex_reg_write); end
        @(negedge clk);
        ex_stall = 0;
    endtask

    task automatic test_back_to_back;
        drive({6'h08, 5'd1, 5'd3, 16'hFFFF}, F_ADDI, 32'h10, 32'h55);
        tick;
        checks++; if (destReg !== 5'd3) begin failures++; $display("FAIL b2b_first got=%0d exp=3", destReg); end
        drive({6'h08, 5'd3, 5'd4, 16'h0002}, F_ADDI, 32'h20, 32'h0);
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%0h exp=0", stall_if); end
        tick;
        checks++; if (destReg !== 5'd4 || busB_out !== 32'h2 || ex_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0d/%0h/%0h exp=4/2/1", destReg, busB_out, ex_valid); end
        drive({6'h23, 5'd2, 5'd5, 16'h0000}, F_LW, 32'h0, 32'h0);
        tick;
        drive({6'h2B, 5'd1, 5'd5, 16'h0004}, F_SW, 32'h0, 32'h0);
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL sw_rs2_stall got=%0h exp=1", stall_if); end
        tick;
        tick;
        checks++; if (ex_mem_write !== 1'b1 || ex_valid !== 1'b1) begin failures++; $display("FAIL sw_enter got=%0h/%0h exp=1/1", ex_mem_write, ex_valid); end
        drive({6'h08, 5'd1, 5'd3, 16'hFFFF}, F_ADDI, 32'h10, 32'h55);
        if_valid = 0;
        tick;
        checks++; if (ex_valid !== 1'b0 || busB_out !== 32'h0 || destReg !== 5'd0) begin failures++; $display("FAIL invalid_bubble got=%0h/%0h/%0d exp=0/0/0", ex_valid, busB_out, destReg); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        test_reset;
        test_addi;
        test_load_use;
        test_no_hazard;
        test_jal;
        test_stall_flush;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
